// File: rtl/alu_result_checker.sv
// Scoreboard for the ALU test top: compares DOUT against DOUT_GOLDEN as IEEE-754 singles
// with a ULP tolerance, keeps pass/fail/max-ULP statistics and captures the first failure.
module alu_result_checker #(
    parameter int unsigned ULP_TOL   = 2,
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          FLOAT_CMP = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CNT_WIDTH-1:0] TEST_COUNT,
    input  logic                 EN,
    input  logic [31:0]          DOUT,
    input  logic [31:0]          DOUT_GOLDEN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_WIDTH-1:0] PASS_CNT,
    output logic [CNT_WIDTH-1:0] FAIL_CNT,
    output logic [31:0]          MAX_ULP,
    output logic                 FAIL_FLAG,
    output logic [CNT_WIDTH-1:0] FIRST_FAIL_IDX,
    output logic [31:0]          FIRST_FAIL_DOUT,
    output logic [31:0]          FIRST_FAIL_GOLDEN
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state_reg;
    state_t state_next;

    logic [CNT_WIDTH-1:0] test_count_reg;
    logic [CNT_WIDTH-1:0] accepted_reg;
    logic                 accept;
    logic                 last_accept;

    // Operand 0 is the ALU result, operand 1 the golden value.
    logic [1:0][31:0] op_in;
    logic [1:0][31:0] key_in;
    logic [1:0]       nan_in;

    logic                 s1_valid_reg;
    logic [31:0]          s1_dout_reg;
    logic [31:0]          s1_golden_reg;
    logic [CNT_WIDTH-1:0] s1_idx_reg;
    logic [1:0][31:0]     s1_key_reg;
    logic [1:0]           s1_nan_reg;

    logic [31:0] ulp;
    logic        pass;

    logic [CNT_WIDTH-1:0] pass_cnt_reg;
    logic [CNT_WIDTH-1:0] fail_cnt_reg;
    logic [31:0]          max_ulp_reg;
    logic                 fail_flag_reg;
    logic [CNT_WIDTH-1:0] ff_idx_reg;
    logic [31:0]          ff_dout_reg;
    logic [31:0]          ff_golden_reg;

    assign accept = (state_reg == ST_RUN) && EN && !START && (accepted_reg < test_count_reg);
    assign last_accept = accept && ((accepted_reg + CNT_ONE) == test_count_reg);

    assign op_in[0] = DOUT;
    assign op_in[1] = DOUT_GOLDEN;

    // Monotonic order key: +0 and -0 both map to 0x8000_0000.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            assign key_in[gi] = op_in[gi][31] ? (32'h8000_0000 - {1'b0, op_in[gi][30:0]})
                                              : (32'h8000_0000 + {1'b0, op_in[gi][30:0]});
            assign nan_in[gi] = (&op_in[gi][30:23]) && (|op_in[gi][22:0]);
        end
    endgenerate

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_IDLE;
            ST_RUN: begin
                if ((accepted_reg == test_count_reg) || last_accept) begin
                    state_next = ST_DRAIN;
                end
            end
            // Nothing enters S1 in DRAIN, so the last result retires on this edge.
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
        if (START) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_reg)
            ST_RUN, ST_DRAIN: BUSY = 1'b1;
            ST_DONE:          DONE = 1'b1;
            default:          ;
        endcase
    end

    // ------------------------------------------------------------ run control
    always_ff @(posedge CLK) begin
        if (RST) begin
            test_count_reg <= '0;
            accepted_reg   <= '0;
        end else if (START) begin
            test_count_reg <= TEST_COUNT;
            accepted_reg   <= '0;
        end else if (accept) begin
            accepted_reg   <= accepted_reg + CNT_ONE;
        end
    end

    // ------------------------------------------------------------ stage 1
    always_ff @(posedge CLK) begin
        if (RST || START) begin
            s1_valid_reg  <= 1'b0;
            s1_dout_reg   <= '0;
            s1_golden_reg <= '0;
            s1_idx_reg    <= '0;
            s1_key_reg    <= '0;
            s1_nan_reg    <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_dout_reg   <= DOUT;
                s1_golden_reg <= DOUT_GOLDEN;
                s1_idx_reg    <= accepted_reg;
                s1_key_reg    <= key_in;
                s1_nan_reg    <= nan_in;
            end
        end
    end

    // ------------------------------------------------------------ stage 2
    generate
        if (FLOAT_CMP) begin : g_float_cmp
            logic [31:0] key_diff;
            assign key_diff = (s1_key_reg[0] >= s1_key_reg[1]) ? (s1_key_reg[0] - s1_key_reg[1])
                                                               : (s1_key_reg[1] - s1_key_reg[0]);
            always_comb begin
                ulp = key_diff;
                if (&s1_nan_reg) begin
                    ulp = 32'h0;
                end else if (|s1_nan_reg) begin
                    ulp = 32'hFFFF_FFFF;
                end
            end
        end else begin : g_exact_cmp
            assign ulp = (s1_dout_reg == s1_golden_reg) ? 32'h0 : 32'hFFFF_FFFF;
        end
    endgenerate

    assign pass = (ulp <= 32'(ULP_TOL));

    always_ff @(posedge CLK) begin
        if (RST || START) begin
            pass_cnt_reg  <= '0;
            fail_cnt_reg  <= '0;
            max_ulp_reg   <= '0;
            fail_flag_reg <= 1'b0;
            ff_idx_reg    <= '0;
            ff_dout_reg   <= '0;
            ff_golden_reg <= '0;
        end else if (s1_valid_reg) begin
            if (ulp > max_ulp_reg) begin
                max_ulp_reg <= ulp;
            end
            if (pass) begin
                if (pass_cnt_reg != CNT_MAX) begin
                    pass_cnt_reg <= pass_cnt_reg + CNT_ONE;
                end
            end else begin
                if (fail_cnt_reg != CNT_MAX) begin
                    fail_cnt_reg <= fail_cnt_reg + CNT_ONE;
                end
                if (!fail_flag_reg) begin
                    fail_flag_reg <= 1'b1;
                    ff_idx_reg    <= s1_idx_reg;
                    ff_dout_reg   <= s1_dout_reg;
                    ff_golden_reg <= s1_golden_reg;
                end
            end
        end
    end

    assign PASS_CNT          = pass_cnt_reg;
    assign FAIL_CNT          = fail_cnt_reg;
    assign MAX_ULP           = max_ulp_reg;
    assign FAIL_FLAG         = fail_flag_reg;
    assign FIRST_FAIL_IDX    = ff_idx_reg;
    assign FIRST_FAIL_DOUT   = ff_dout_reg;
    assign FIRST_FAIL_GOLDEN = ff_golden_reg;

endmodule
